serial_byte_rx: RTL and testbench
=================================

Name: serial_byte_rx

Overview:
- Receive-side counterpart of the LED bit-serial transmitter: recovers bytes from a single-wire, LSB-first serial stream on a GPIO pin.
- Frame: idle high, start bit low, DATA_BITS data bits LSB first, one stop bit high.
- Line is asynchronous to sys_clk; block oversamples at CLKS_PER_BIT clocks per bit, samples mid-bit, presents each byte with a one-cycle valid strobe.
- Sits between a board pin and a downstream byte consumer (LED pattern logic / memory writer).

Parameters:
- CLKS_PER_BIT, 16, sys_clk cycles per serial bit; even, >= 4.
- DATA_BITS, 8, data bits per frame; range 1..8.

Ports:
- sys_clk  input  1  system clock (OSCH-derived); all logic on rising edge.
- sys_rst  input  1  synchronous reset, active-low (0 = reset), sampled on sys_clk rising edge.
- rx_in  input  1  asynchronous serial line; idle high.
- data_out  output  DATA_BITS  last correctly framed byte; bit 0 = first received data bit.
- data_valid  output  1  one-cycle strobe; data_out updated this cycle.
- frame_err  output  1  one-cycle strobe; stop bit sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (sys_rst==0 at clock edge): data_out=0, data_valid=0, frame_err=0, busy=0, state=IDLE, counters=0, both synchroniser flops=1. Reset overrides all other updates in the same cycle.
- Reset mid-frame: partial byte discarded; no data_valid, no frame_err. After release, IDLE waits for the next falling edge.
- Input: 2-flop synchroniser. rxs denotes the second flop's output. All decisions use rxs only.
- Definitions: H = CLKS_PER_BIT/2; C = CLKS_PER_BIT. cnt counts 0..C-1; bit index counts 0..DATA_BITS-1.
- IDLE: if rxs==0, go to START with cnt=0. Detection cycle is called T0.
- START: cnt increments each cycle. At cnt==H-1, i.e. cycle T0+H:
  - rxs==0: go to DATA, cnt=0, bit index=0.
  - rxs==1: glitch; return to IDLE with no strobe.
- DATA: sample at cnt==C-1, at cycles T0+H+k*C for k=1..DATA_BITS.
  - Shift right with the new bit into the MSB, so the first bit ends at bit 0 after DATA_BITS shifts.
  - cnt resets to 0 on each sample.
  - After the last bit, go to STOP.
- STOP: sample at cnt==C-1, cycle T0+H+(DATA_BITS+1)*C.
  - rxs==1: next cycle data_out=shift register, data_valid=1 for exactly 1 cycle; go to IDLE.
  - rxs==0: next cycle frame_err=1 for exactly 1 cycle, data_out unchanged; go to WAIT_HIGH.
- WAIT_HIGH: remain until rxs==1, then go to IDLE. This prevents a held-low break from retriggering; one frame_err per break.
- Latency: data_valid asserted H+(DATA_BITS+1)*C+1 cycles after T0. Default: 8+144+1 = 153.
- Back-to-back frames: IDLE is entered the cycle after the stop sample. A start edge arriving in the second half of the stop bit is accepted, giving zero inter-frame gap tolerance.
- data_valid and frame_err are never high in the same cycle. data_out holds its value between strobes.
- busy=0 in IDLE, 1 in all other states.

Test Plan:
- C=16: send 0xA5 framed (bits 1,0,1,0,0,1,0,1 then stop) -> data_valid single pulse 153 cycles after detection, data_out=0xA5, frame_err stays 0.
- Back-to-back 0x00 then 0xFF, no idle gap -> two data_valid pulses exactly 160 cycles apart, data_out 0x00 then 0xFF.
- rx_in low for 4 cycles, then high -> state returns to IDLE, busy drops, no data_valid, no frame_err.
- Valid 0x12, then 0x3C with stop bit driven low -> frame_err pulse once, data_out remains 0x12; after line returns high, a following 0x7E is received correctly.
- Line held low 1000 cycles (break) -> exactly one frame_err, busy stays high until line high; then a normal 0x55 is received.
- sys_rst=0 for 1 cycle during bit 4 of 0xC3 -> outputs all 0 next cycle, no strobe for that frame; next framed 0x81 yields data_out=0x81.

Source files
------------

// File: rtl/serial_byte_rx.sv
// Bit-serial line receiver: recovers LSB-first frames (start, DATA_BITS data, stop)
// from an asynchronous idle-high line, sampling each bit at its midpoint.
module serial_byte_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s1;
    logic                 rxs;

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            rx_s1      <= 1'b1;
            rxs        <= 1'b1;
        end else begin
            rx_s1      <= rx_in;
            rxs        <= rx_s1;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                // Re-check the start bit at its midpoint to reject short glitches.
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt     <= '0;
                        shreg   <= DATA_BITS'({rxs, shreg} >> 1);
                        bit_idx <= bit_idx + BW'(1);
                        if (bit_idx == BIT_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_FULL) begin
                        cnt <= '0;
                        if (rxs) begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // A held-low break reports once, then waits for the line to recover.
                WAIT_HIGH: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_byte_rx.sv
// Bench for serial_byte_rx: directed scenarios plus random frames, checked every
// cycle against a frame-offset reference model and an expected-byte queue.
module tb_serial_byte_rx;

    localparam int C  = 16;
    localparam int DB = 8;
    localparam int H  = C / 2;
    localparam int SYNC_LAT = 2;

    logic          sys_clk;
    logic          sys_rst;
    logic          rx_in;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          busy;
    logic [2:0]    dbg_state;

    serial_byte_rx #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on the synchronised line: once a low is seen in idle at edge t0, the
    // start is confirmed at t0+H, data bits are read at t0+H+k*C, the stop at
    // t0+H+(DB+1)*C.
    typedef enum int {M_IDLE, M_FRAME, M_WAIT} mode_t;
    mode_t         m_mode = M_IDLE;
    logic          m_s1 = 1'b1, m_s2 = 1'b1;
    int            m_t0 = 0;
    logic [DB-1:0] m_bits = '0;
    logic [DB-1:0] exp_data = '0;
    logic          exp_valid = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;
    logic [DB-1:0] exp_q[$];

    always @(posedge sys_clk) begin
        int   off;
        int   k;
        logic r;
        cyc++;
        r = m_s2;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (!sys_rst) begin
            m_mode   = M_IDLE;
            m_s1     = 1'b1;
            m_s2     = 1'b1;
            exp_data = '0;
        end else begin
            case (m_mode)
                M_IDLE: if (r == 1'b0) begin
                    m_t0   = cyc;
                    m_mode = M_FRAME;
                end
                M_FRAME: begin
                    off = cyc - m_t0;
                    if (off == H) begin
                        if (r) m_mode = M_IDLE;
                    end else if (off > H && (off - H) % C == 0) begin
                        k = (off - H) / C;
                        if (k <= DB) begin
                            m_bits[k-1] = r;
                        end else begin
                            if (r) begin
                                exp_valid = 1'b1;
                                exp_data  = m_bits;
                                exp_q.push_back(m_bits);
                                m_mode = M_IDLE;
                            end else begin
                                exp_err = 1'b1;
                                m_mode  = M_WAIT;
                            end
                        end
                    end
                end
                M_WAIT: if (r) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
            m_s2 = m_s1;
            m_s1 = rx_in;
        end
        exp_busy = (m_mode != M_IDLE);
    end

    // ---------------- monitor / scoreboard ----------------
    int            valid_cnt = 0;
    int            err_cnt   = 0;
    int            valid_cyc[$];
    logic [DB-1:0] valid_dat[$];

    always @(negedge sys_clk) begin
        logic [DB-1:0] e;
        check("data_valid", data_valid, exp_valid);
        check("frame_err", frame_err, exp_err);
        check("busy", busy, exp_busy);
        check("data_out", data_out, exp_data);
        if (data_valid && frame_err) check("valid_err_exclusive", 1, 0);
        if (frame_err) err_cnt++;
        if (data_valid) begin
            valid_cnt++;
            valid_cyc.push_back(cyc);
            valid_dat.push_back(data_out);
            if (exp_q.size() == 0) begin
                check("sb_unexpected_byte", data_out, '1 ^ data_out);
            end else begin
                e = exp_q.pop_front();
                check("sb_byte", data_out, e);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic hold(input logic v, input int n);
        rx_in = v;
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input logic stop);
        hold(1'b0, C);
        for (int i = 0; i < DB; i++) hold(b[i], C);
        hold(stop, C);
        rx_in = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int n0, e0, t_fall;

    initial begin
        sys_rst = 1'b0;
        rx_in   = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_data_out", data_out, 0);
        check("reset_busy", busy, 0);
        check("reset_valid", data_valid, 0);
        sys_rst = 1'b1;
        hold(1'b1, 20);

        // 0xA5: single strobe, latency 153 after detection plus the synchroniser
        n0 = valid_cnt; e0 = err_cnt; t_fall = cyc;
        send_frame(8'hA5, 1'b1);
        hold(1'b1, 10);
        check("a5_count", valid_cnt - n0, 1);
        check("a5_latency", valid_cyc[$] - t_fall, SYNC_LAT + 1 + H + (DB + 1) * C);
        check("a5_data", valid_dat[$], 8'hA5);
        check("a5_no_err", err_cnt - e0, 0);

        // back-to-back 0x00 then 0xFF with no gap
        n0 = valid_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold(1'b1, 10);
        check("b2b_count", valid_cnt - n0, 2);
        check("b2b_spacing", valid_cyc[$] - valid_cyc[$-1], 10 * C);
        check("b2b_first", valid_dat[$-1], 8'h00);
        check("b2b_second", valid_dat[$], 8'hFF);

        // short glitch is rejected
        n0 = valid_cnt; e0 = err_cnt;
        hold(1'b0, 4);
        hold(1'b1, 30);
        check("glitch_busy", busy, 0);
        check("glitch_no_valid", valid_cnt - n0, 0);
        check("glitch_no_err", err_cnt - e0, 0);

        // framing error keeps the last good byte, then recovery
        send_frame(8'h12, 1'b1);
        e0 = err_cnt;
        send_frame(8'h3C, 1'b0);
        hold(1'b1, 10);
        check("ferr_count", err_cnt - e0, 1);
        check("ferr_data_kept", data_out, 8'h12);
        send_frame(8'h7E, 1'b1);
        hold(1'b1, 10);
        check("ferr_recover", valid_dat[$], 8'h7E);

        // held-low break: one error, busy until the line returns
        e0 = err_cnt;
        hold(1'b0, 1000);
        check("break_busy", busy, 1);
        check("break_err_once", err_cnt - e0, 1);
        hold(1'b1, 10);
        check("break_idle", busy, 0);
        check("break_err_total", err_cnt - e0, 1);
        send_frame(8'h55, 1'b1);
        hold(1'b1, 10);
        check("break_recover", valid_dat[$], 8'h55);

        // reset pulse in the middle of data bit 4 of 0xC3
        n0 = valid_cnt;
        fork
            send_frame(8'hC3, 1'b1);
            begin
                repeat (5 * C + H) @(posedge sys_clk);
                #1 sys_rst = 1'b0;
                @(posedge sys_clk);
                #1 sys_rst = 1'b1;
                check("midrst_data", data_out, 0);
                check("midrst_busy", busy, 0);
                check("midrst_no_valid", valid_cnt - n0, 0);
            end
        join
        hold(1'b1, 300);
        send_frame(8'h81, 1'b1);
        hold(1'b1, 10);
        check("midrst_recover", valid_dat[$], 8'h81);

        // random frames, bad stops, glitches and gaps
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                hold(1'b0, $urandom_range(1, H + 4));
                rx_in = 1'b1;
            end else begin
                send_frame(DB'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0));
            end
            hold(1'b1, $urandom_range(0, 30));
        end

        hold(1'b1, 400);
        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
